// File: rtl/timer_pkg.sv
// Shared types and constants for the mm:ss countdown timer.
package timer_pkg;

  localparam int DIGIT_W      = 4;
  localparam int SEC_TENS_MAX = 5;
  localparam int ONES_MAX     = 9;
  localparam int MIN_TENS_MAX = 5;
  localparam int NUM_DIGITS   = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Digit index 0 is seconds-ones, 3 is minutes-tens; even digits are ones.
  function automatic int digit_max(input int idx);
    case (idx)
      1:       return SEC_TENS_MAX;
      3:       return MIN_TENS_MAX;
      default: return ONES_MAX;
    endcase
  endfunction

  // Saturate an out-of-range BCD load value to the digit's maximum.
  function automatic digit_t clamp_digit(input digit_t val, input digit_t max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control, load and status signals between the timer and its host.
interface countdown_timer_if;
  import timer_pkg::*;

  logic   tick_in;
  logic   start_stop;
  logic   clear;
  logic   load;
  digit_t load_mt;
  digit_t load_mo;
  digit_t load_st;
  digit_t load_so;
  digit_t min_tens;
  digit_t min_ones;
  digit_t sec_tens;
  digit_t sec_ones;
  logic   running;
  logic   done;
  logic   expire;

  modport master (
    output tick_in, start_stop, clear, load,
    output load_mt, load_mo, load_st, load_so,
    input  min_tens, min_ones, sec_tens, sec_ones,
    input  running, done, expire
  );

  modport slave (
    input  tick_in, start_stop, clear, load,
    input  load_mt, load_mo, load_st, load_so,
    output min_tens, min_ones, sec_tens, sec_ones,
    output running, done, expire
  );

endinterface

// File: rtl/bcd_down_digit.sv
// One registered BCD down-counting digit; wraps 0 -> MAX and signals a borrow.
module bcd_down_digit
  import timer_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   dec,
  input  logic   load,
  input  digit_t load_val,
  output digit_t digit,
  output logic   borrow_out
);

  localparam digit_t MAX_D = digit_t'(MAX);

  digit_t r_digit;

  // Load (clamped) takes precedence over a decrement in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digit <= '0;
    end else if (load) begin
      r_digit <= clamp_digit(load_val, MAX_D);
    end else if (dec) begin
      r_digit <= (r_digit == '0) ? MAX_D : r_digit - digit_t'(1);
    end
  end

  assign digit      = r_digit;
  assign borrow_out = dec && (r_digit == '0);

endmodule

// File: rtl/countdown_timer.sv
// mm:ss countdown timer: tick edge detect, control FSM and a four-digit BCD chain.
module countdown_timer
  import timer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  countdown_timer_if.slave   bus
);

  state_t r_state;
  state_t w_state_next;
  logic   r_tick_q;
  logic   r_expire;
  logic   w_expire_next;
  logic   w_tick;
  logic   w_load_ok;
  logic   w_load_en;
  logic   w_dec;
  logic   w_zero;
  logic   w_at_one;

  digit_t                w_digit    [NUM_DIGITS];
  digit_t                w_load_raw [NUM_DIGITS];
  digit_t                w_load_val [NUM_DIGITS];
  logic [NUM_DIGITS:0]   w_borrow;

  // One tick per rising edge of the divided clock level.
  assign w_tick = bus.tick_in && !r_tick_q;

  // A load only lands when the count is not being consumed.
  assign w_load_ok = bus.load && ((r_state == ST_IDLE) || (r_state == ST_PAUSE));
  // Clear is a load of zeros into every digit.
  assign w_load_en = bus.clear || w_load_ok;

  // Ticks count down only in RUN, and lose to clear and start_stop.
  assign w_dec = (r_state == ST_RUN) && !bus.clear && !bus.start_stop && w_tick;

  assign w_load_raw[0] = bus.load_so;
  assign w_load_raw[1] = bus.load_st;
  assign w_load_raw[2] = bus.load_mo;
  assign w_load_raw[3] = bus.load_mt;

  assign w_borrow[0] = w_dec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_load_val[gi] = bus.clear ? digit_t'(0) : w_load_raw[gi];

      bcd_down_digit #(
        .MAX (digit_max(gi))
      ) u_digit (
        .clk        (clk),
        .rst        (rst),
        .dec        (w_borrow[gi]),
        .load       (w_load_en),
        .load_val   (w_load_val[gi]),
        .digit      (w_digit[gi]),
        .borrow_out (w_borrow[gi+1])
      );
    end
  endgenerate

  assign w_zero   = (w_digit[3] == '0) && (w_digit[2] == '0) &&
                    (w_digit[1] == '0) && (w_digit[0] == '0);
  assign w_at_one = (w_digit[3] == '0) && (w_digit[2] == '0) &&
                    (w_digit[1] == '0) && (w_digit[0] == digit_t'(1));

  // Next-state and expire decode, in priority clear > load > start_stop > tick.
  always_comb begin
    w_state_next  = r_state;
    w_expire_next = 1'b0;
    if (bus.clear) begin
      w_state_next = ST_IDLE;
    end else if (w_load_ok) begin
      w_state_next = r_state;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start_stop && !w_zero) w_state_next = ST_RUN;
        end
        ST_RUN: begin
          if (bus.start_stop) begin
            w_state_next = ST_PAUSE;
          end else if (w_dec && (w_at_one || w_borrow[NUM_DIGITS])) begin
            // The underflow term only guards against an unreachable 00:00 in RUN.
            w_state_next  = ST_DONE;
            w_expire_next = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (bus.start_stop) w_state_next = w_zero ? ST_IDLE : ST_RUN;
        end
        ST_DONE: begin
          if (bus.start_stop) w_state_next = ST_IDLE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // State, tick history and the registered expire pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_tick_q <= 1'b0;
      r_expire <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_tick_q <= bus.tick_in;
      r_expire <= w_expire_next;
    end
  end

  assign bus.sec_ones = w_digit[0];
  assign bus.sec_tens = w_digit[1];
  assign bus.min_ones = w_digit[2];
  assign bus.min_tens = w_digit[3];
  assign bus.running  = (r_state == ST_RUN);
  assign bus.done     = (r_state == ST_DONE);
  assign bus.expire   = r_expire;

endmodule

// File: tb/tb_countdown_timer.sv
// Randomised and directed stimulus against a seconds-based reference model.
module tb_countdown_timer;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  typedef struct {
    logic [18:0] v;
    string       tag;
  } exp_t;

  logic clk;
  logic rst;
  countdown_timer_if bus_if();

  countdown_timer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   txn      = 0;
  exp_t exp_q[$];

  int m_secs;
  int m_st;
  bit m_prev;
  bit tin_r;

  function automatic int clampv(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [18:0] dut_vec();
    return {bus_if.min_tens, bus_if.min_ones, bus_if.sec_tens, bus_if.sec_ones,
            bus_if.running, bus_if.done, bus_if.expire};
  endfunction

  // Drive one cycle of inputs (called at negedge+1), predict the result after the next edge.
  task automatic cyc(input bit ss, input bit clr, input bit ld,
                     input int a, input int b, input int c, input int d,
                     input bit tin, input string tag);
    bit   tick;
    bit   ex;
    exp_t e;
    bus_if.start_stop = ss;
    bus_if.clear      = clr;
    bus_if.load       = ld;
    bus_if.load_mt    = 4'(a);
    bus_if.load_mo    = 4'(b);
    bus_if.load_st    = 4'(c);
    bus_if.load_so    = 4'(d);
    bus_if.tick_in    = tin;
    tick   = tin && !m_prev;
    m_prev = tin;
    ex     = 1'b0;
    if (clr) begin
      m_st   = M_IDLE;
      m_secs = 0;
    end else if (ld && (m_st == M_IDLE || m_st == M_PAUSE)) begin
      m_secs = (clampv(a, 5) * 10 + clampv(b, 9)) * 60 + clampv(c, 5) * 10 + clampv(d, 9);
    end else begin
      case (m_st)
        M_IDLE:  if (ss && m_secs != 0) m_st = M_RUN;
        M_RUN: begin
          if (ss) m_st = M_PAUSE;
          else if (tick) begin
            m_secs = m_secs - 1;
            if (m_secs == 0) begin
              m_st = M_DONE;
              ex   = 1'b1;
            end
          end
        end
        M_PAUSE: if (ss) m_st = (m_secs != 0) ? M_RUN : M_IDLE;
        default: if (ss) m_st = M_IDLE;
      endcase
    end
    e.v   = {4'(m_secs / 600), 4'((m_secs / 60) % 10), 4'((m_secs % 60) / 10),
             4'(m_secs % 10), m_st == M_RUN, m_st == M_DONE, ex};
    e.tag = tag;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic idle_cyc(input bit tin, input string tag);
    cyc(0, 0, 0, 0, 0, 0, 0, tin, tag);
  endtask

  task automatic tick_pair(input string tag);
    idle_cyc(1, tag);
    idle_cyc(0, tag);
  endtask

  // Monitor: compare each predicted response two time units after the edge it belongs to.
  always begin
    exp_t        e;
    logic [18:0] got;
    @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = dut_vec();
      checks++;
      txn++;
      if (got !== e.v) begin
        failures++;
        $display("FAIL txn %0d %s got=%h exp=%h", txn, e.tag, got, e.v);
      end else begin
        $display("txn %0d %s ok %h", txn, e.tag, got);
      end
    end
  end

  initial begin
    rst               = 1'b1;
    bus_if.tick_in    = 1'b0;
    bus_if.start_stop = 1'b0;
    bus_if.clear      = 1'b0;
    bus_if.load       = 1'b0;
    bus_if.load_mt    = '0;
    bus_if.load_mo    = '0;
    bus_if.load_st    = '0;
    bus_if.load_so    = '0;
    m_secs = 0;
    m_st   = M_IDLE;
    m_prev = 1'b0;
    tin_r  = 1'b0;

    #1;
    checks++;
    if (dut_vec() !== 19'd0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", dut_vec(), 19'd0);
    end else $display("txn reset_state ok");

    @(negedge clk);
    #1;
    rst = 1'b0;

    // 01:00 counted fully down with one expire pulse.
    cyc(0, 0, 1, 0, 1, 0, 0, 0, "load_0100");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "start_0100");
    for (int i = 0; i < 60; i++) tick_pair("tick_0100");
    idle_cyc(0, "done_hold");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "done_to_idle");

    // 10:00 minus one second borrows through every digit.
    cyc(0, 0, 1, 1, 0, 0, 0, 0, "load_1000");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "start_1000");
    tick_pair("borrow_all");
    cyc(0, 1, 0, 0, 0, 0, 0, 0, "clear");

    // Pause with a coincident tick, ticks ignored in PAUSE, resume.
    cyc(0, 0, 1, 0, 0, 0, 5, 0, "load_0005");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "start_0005");
    cyc(1, 0, 0, 0, 0, 0, 0, 1, "pause_with_tick");
    idle_cyc(0, "paused");
    for (int i = 0; i < 3; i++) tick_pair("pause_tick");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "resume");
    tick_pair("run_tick");

    // Clear beats load in PAUSE; start at 00:00 stays IDLE.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "pause_again");
    cyc(0, 1, 1, 3, 3, 3, 3, 0, "clear_and_load");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "start_at_zero");

    // Clamped load, then a load during RUN is ignored.
    cyc(0, 0, 1, 7, 12, 9, 15, 0, "load_clamp");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "start_5959");
    cyc(0, 0, 1, 1, 2, 3, 4, 0, "load_in_run");
    tick_pair("run_5959");

    // Held tick level gives one decrement only.
    for (int i = 0; i < 10; i++) idle_cyc(1, "tick_held");
    idle_cyc(0, "tick_low");

    // Asynchronous reset between clock edges during RUN.
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== 19'd0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", dut_vec(), 19'd0);
    end else $display("txn async_reset ok");
    bus_if.tick_in = 1'b1;
    @(negedge clk);
    #1;
    rst    = 1'b0;
    m_secs = 0;
    m_st   = M_IDLE;
    m_prev = 1'b0;
    idle_cyc(1, "tick_after_reset");
    idle_cyc(0, "post_reset");

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      int  r;
      bit  ss;
      bit  clr;
      bit  ld;
      int  a;
      int  b;
      int  c;
      int  d;
      r   = int'($urandom_range(0, 99));
      clr = (r < 2);
      ld  = (r >= 2) && (r < 8);
      ss  = (r >= 8) && (r < 16);
      if ($urandom_range(0, 1) == 1) begin
        a = 0;
        b = 0;
        c = int'($urandom_range(0, 1));
        d = int'($urandom_range(0, 15));
      end else begin
        a = int'($urandom_range(0, 15));
        b = int'($urandom_range(0, 15));
        c = int'($urandom_range(0, 15));
        d = int'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 1) == 1) tin_r = ~tin_r;
      cyc(ss, clr, ld, a, b, c, d, tin_r, "random");
    end

    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 tick_in  input  1  divided-clock level from the upstream divider, synchronous to clk, period >= 2 clk cycles.
REQ-004 start_stop  input  1  single-cycle pulse; start/pause/resume request.
REQ-005 clear  input  1  single-cycle pulse; abort to IDLE and zero the count.
REQ-006 load  input  1  single-cycle pulse; capture load_* digits.
REQ-007 load_mt, load_mo, load_st, load_so  input  4 each  BCD load digits: minute tens/ones, second tens/ones.
REQ-008 min_tens, min_ones, sec_tens, sec_ones  output  4 each  current count, BCD, registered.
REQ-009 running  output  1  high while state is RUN.
REQ-010 done  output  1  high while state is DONE.
REQ-011 expire  output  1  one-cycle pulse on entry to DONE.

Function
REQ-012 Tick detect: tick_q registers tick_in; tick = tick_in AND NOT tick_q; one tick per tick_in rising edge, in the cycle tick_in first reads high.
REQ-013 Count range 00:00..59:59; digits always valid BCD (tens 0-5, ones 0-9).
REQ-014 FSM states IDLE, RUN, PAUSE, DONE; encoding free.
REQ-015 Input priority per cycle: clear > load > start_stop > tick.
REQ-016 clear in any state: next state IDLE, all digits 0.
REQ-017 load accepted only in IDLE or PAUSE; ignored in RUN and DONE.
REQ-018 Load clamps each digit: tens > 5 -> 5; ones > 9 -> 9; state unchanged.
REQ-019 IDLE: start_stop with count != 00:00 -> RUN; with count == 00:00 -> stay IDLE.
REQ-020 RUN: start_stop -> PAUSE, same-cycle tick discarded; tick otherwise decrements count by one second.
REQ-021 Decrement: sec_ones 0 -> 9 with borrow; sec_tens 0 -> 5 with borrow; min_ones 0 -> 9 with borrow; min_tens decrements on borrow.
REQ-022 RUN: tick at count 00:01 -> count 00:00 and state DONE at the same clk edge; expire high the following cycle only.
REQ-023 PAUSE: ticks ignored, count held; start_stop -> RUN if count != 00:00, else IDLE.
REQ-024 DONE: count held at 00:00; start_stop -> IDLE.
REQ-025 Tick latency: count update visible on outputs one clk after the tick cycle.
REQ-026 tick_in held high does not re-trigger; the next tick requires a low-then-high transition.

Reset
REQ-027 rst asserted: state IDLE, all digits 0, tick_q 0, running/done/expire 0, immediately, regardless of clk.
REQ-028 rst mid-RUN discards the count; tick_in already high at rst release produces a tick on the first clock after release (tick_q reset 0), ignored because state is IDLE.

Structure
REQ-029 Package timer_pkg holds: state enum, BCD digit width (4), SEC_TENS_MAX 5, ONES_MAX 9, MIN_TENS_MAX 5.
REQ-030 Sub-module bcd_down_digit (parameter MAX; inputs dec, load, load_val; outputs digit, borrow_out) instantiated four times, chained via borrow.
REQ-031 FSM, tick detect, and output registers live in countdown_timer; target 150-300 lines total.

Verification
REQ-032 Load 01:00, start, 60 ticks -> count 00:00, done=1, exactly one expire pulse, running=0.
REQ-033 Load 10:00, start, 1 tick -> 09:59 (borrow through all four digits).
REQ-034 RUN at 00:05; start_stop and tick in the same cycle -> PAUSE, count stays 00:05; 3 further ticks -> still 00:05; start_stop -> RUN.
REQ-035 Load digits 7,12,9,15 in IDLE -> 59:59 (clamped); load pulse while RUN -> ignored.
REQ-036 clear and load in the same cycle during PAUSE -> IDLE, 00:00; start_stop at 00:00 -> stays IDLE.
REQ-037 tick_in held high 10 cycles -> single decrement; rst asserted mid-RUN between clk edges -> outputs 0 immediately.
